share_unmasker: RTL
===================

SHARE_UNMASKER -- requirements
Module: share_unmasker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of each share and of the recombined word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the input share pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the input pair this cycle.
REQ-006 SHALL have ports X0 and X1, input, WIDTH bits each: Boolean shares of the secret, where secret = X0 ^ X1.
REQ-007 SHALL have port rN, input, WIDTH bits: fresh refresh randomness, sampled only on an accepted transfer.
REQ-008 SHALL have port out_valid, output, 1 bit: Y holds a recombined word.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts Y.
REQ-010 SHALL have port Y, output, WIDTH bits: the unmasked word.
REQ-011 SHALL have port count, output, 16 bits: number of words delivered on the output.

Function
REQ-012 An input transfer SHALL occur when in_valid && in_ready at a rising clk edge; an output transfer SHALL occur when out_valid && out_ready at a rising clk edge.
REQ-013 Stage 1 SHALL register the shares separately as S0 = X0 ^ rN and S1 = X1 ^ rN, together with a valid flag v1; X0 and X1 SHALL never be combined combinationally before this register.
REQ-014 Stage 2 SHALL register Y = S0 ^ S1 with valid flag v2; out_valid SHALL equal v2.
REQ-015 Stage 2 SHALL advance (adv2) when !v2 || out_ready; stage 1 SHALL advance (adv1) when !v1 || adv2.
REQ-016 in_ready SHALL equal adv1, which is combinational from out_ready, v1 and v2 only; it SHALL not depend on in_valid.
REQ-017 Latency SHALL be 2 cycles: a word accepted at edge N SHALL present out_valid at edge N+2 when out_ready is held high.
REQ-018 With out_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-019 When out_ready is low and both stages are full: in_ready SHALL be 0, and Y, S0, S1 and both valid flags SHALL hold unchanged.
REQ-020 A bubble in stage 2 SHALL be filled from stage 1 even while out_ready is low.
REQ-021 When in_valid is low and stage 1 advances, v1 SHALL clear; register data may be left stale but SHALL not be presented as valid.
REQ-022 count SHALL increment by 1 on each output transfer and SHALL saturate at 16'hFFFF.
REQ-023 Y, as sampled during an output transfer, SHALL equal X0 ^ X1 of the corresponding input, in order, with no loss or duplication.

Reset
REQ-024 When rst_n is low, v1, v2, S0, S1, Y and count SHALL clear to 0 asynchronously; therefore out_valid = 0 and in_ready = 1.
REQ-025 Reset asserted mid-stream SHALL discard every in-flight word; the first word accepted after reset deassertion SHALL be the first word output.

Configuration
REQ-026 Macro SHARE_UNMASKER_REFRESH_EN defined: stage 1 SHALL apply the rN refresh of REQ-013.
REQ-027 Macro SHARE_UNMASKER_REFRESH_EN undefined: stage 1 SHALL register S0 = X0 and S1 = X1, and rN SHALL be ignored; latency, handshake and Y SHALL be identical to the defined case.

Verification
REQ-028 After reset, with out_ready=1: drive X0=8'hA5, X1=8'h0F, rN=8'h3C for one cycle -> out_valid two cycles later with Y=8'hAA, and count=1 after the transfer.
REQ-029 Stream 4 words back-to-back with out_ready=1, where X0^X1 = 01, 02, 03, 04 and rN is random -> Y = 01, 02, 03, 04 on consecutive cycles with no bubbles.
REQ-030 Fill the pipe with 2 words, then hold out_ready=0 for 5 cycles -> in_ready=0, and Y and out_valid remain stable throughout; release out_ready -> both words delivered in order.
REQ-031 Assert rst_n low while 2 words are in flight -> out_valid=0, count=0 and in_ready=1 immediately; no stale word appears after reset is released.
REQ-032 Preload count to 16'hFFFE by streaming, then deliver 3 more words -> count stays at 16'hFFFF.
REQ-033 Run REQ-028 and REQ-029 with and without SHARE_UNMASKER_REFRESH_EN -> identical Y values and timing in both builds; with the macro defined, the internal S0 observed in simulation equals X0^rN.

Source files
------------

// File: rtl/share_unmasker.sv
// +--------------------------------------------------------------------------+
// | share_unmasker : two-stage recombiner of Boolean shares (Y = X0 ^ X1)    |
// | Optional macro SHARE_UNMASKER_REFRESH_EN: re-mask both shares with rN     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module share_unmasker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] rN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [15:0]      count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [WIDTH-1:0] S0;
  logic [WIDTH-1:0] S1;
  logic             v1;
  logic             v2;
  logic             adv1;
  logic             adv2;
  logic             out_fire;
  logic [WIDTH-1:0] share0_next;
  logic [WIDTH-1:0] share1_next;

  // Handshake depends only on out_ready and the valid flags, never on in_valid.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;
  assign out_fire  = v2 && out_ready;

`ifdef SHARE_UNMASKER_REFRESH_EN
  // Both shares carry the same mask, so it cancels in stage 2.
  assign share0_next = X0 ^ rN;
  assign share1_next = X1 ^ rN;
`else
  logic unused_rn;
  assign unused_rn   = ^rN;
  assign share0_next = X0;
  assign share1_next = X1;
`endif

  // Stage 1: shares kept in separate registers; no X0/X1 mixing before here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      S0 <= '0;
      S1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        S0 <= share0_next;
        S1 <= share1_next;
      end
    end
  end

  // Stage 2: recombination; fills a bubble even while out_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      Y  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        Y <= S0 ^ S1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (out_fire && (count != COUNT_MAX)) begin
      count <= count + 16'd1;
    end
  end

  // A full, stalled pipe must hold every register.
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (v1 && v2 && !out_ready) |=> (v1 && v2 && $stable(Y) && $stable(S0) && $stable(S1)));

  a_count_sat : assert property (@(posedge clk) disable iff (!rst_n)
    (count == COUNT_MAX) |=> (count == COUNT_MAX));

endmodule

`default_nettype wire
